mem_lsu: RTL and testbench

- Memory-access stage, directly downstream of the execute stage.
- Consumes the ALU result (used as the data address), the store data (rs2), the branch target and the zero/force-taken flag.
- Drives a request/grant/rvalid data-memory port and performs byte-lane alignment and load sign/zero extension.
- Produces a registered writeback bundle, a stall to upstream stages, and the PC-redirect decision.

---
 rtl/mem_lsu.sv | 209 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage between execute and writeback.
// Turns the ALU result into a data address and drives a req/gnt/rvalid
// memory port. Handles store byte-lane alignment and load sign/zero
// extension. Produces a registered writeback bundle, an upstream stall
// and the PC-redirect decision.
//
// Ports
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_valid               instruction present in stage
//   i_resultALU           ALU result / effective address
//   i_storeData           rs2 data for stores
//   i_outAddr, i_zero     branch target and branch/forced-jump condition
//   i_ctrlMEM             [5] branch, [4] memRead, [3] memWrite, [2:0] funct3
//   o_stall               hold upstream (inputs held stable while high)
//   o_pcSrc, o_branchAddr combinational redirect decision and target
//   o_mem*, i_mem*        data-memory request/grant/rvalid port
//   o_valid, o_resultALU, o_loadData, o_misaligned, o_busErr
//                         registered writeback bundle (flags qualified by o_valid)
module mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_resultALU,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_outAddr,
    input  logic        i_zero,
    input  logic [5:0]  i_ctrlMEM,
    output logic        o_stall,
    output logic        o_pcSrc,
    output logic [31:0] o_branchAddr,
    output logic        o_memReq,
    output logic        o_memWe,
    output logic [31:0] o_memAddr,
    output logic [3:0]  o_memBe,
    output logic [31:0] o_memWdata,
    input  logic        i_memGnt,
    input  logic        i_memRvalid,
    input  logic [31:0] i_memRdata,
    output logic        o_valid,
    output logic [31:0] o_resultALU,
    output logic [31:0] o_loadData,
    output logic        o_misaligned,
    output logic        o_busErr
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               branch, mem_read, mem_write;
    logic [2:0]         funct3;
    logic [1:0]         off;
    logic               is_byte, is_half, aligned, mem_op, mem_go;
    logic               req_c, complete_c, abort_c, timeout_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c, shifted, ext_c;

    logic               valid_d, mis_d, err_d;
    logic [31:0]        result_d, load_d;

    // Control decode; memRead and memWrite together is not a memory op
    assign branch    = i_ctrlMEM[5];
    assign mem_read  = i_ctrlMEM[4];
    assign mem_write = i_ctrlMEM[3];
    assign funct3    = i_ctrlMEM[2:0];
    assign off       = i_resultALU[1:0];
    assign is_byte   = (funct3[1:0] == 2'b00);
    assign is_half   = (funct3[1:0] == 2'b01);
    assign aligned   = is_byte | (is_half & ~off[0]) | (~is_byte & ~is_half & (off == 2'b00));
    assign mem_op    = i_valid & (mem_read ^ mem_write);
    assign mem_go    = mem_op & aligned;

    // Branch redirect is independent of the memory stall
    assign o_pcSrc      = i_valid & branch & i_zero;
    assign o_branchAddr = i_outAddr;

    // Store lane steering
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_storeData;
        if (is_byte) begin
            be_c    = 4'(4'b0001 << off);
            wdata_c = {4{i_storeData[7:0]}};
        end else if (is_half) begin
            be_c    = 4'(4'b0011 << off);
            wdata_c = {2{i_storeData[15:0]}};
        end
    end

    assign o_memAddr  = {i_resultALU[31:2], 2'b00};
    assign o_memWe    = mem_write;
    assign o_memBe    = be_c;
    assign o_memWdata = wdata_c;

    // Load lane extraction and extension; funct3[2] selects zero-extension
    assign shifted = i_memRdata >> {off, 3'b000};

    always_comb begin
        ext_c = shifted;
        if (is_byte) begin
            ext_c = {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            ext_c = {{16{~funct3[2] & shifted[15]}}, shifted[15:0]};
        end
    end

    // cnt_q counts cycles already spent on the transaction, including the
    // IDLE cycle in which the request was first presented.
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and transaction control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_c      = 1'b0;
        complete_c = 1'b0;
        abort_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    req_c = 1'b1;
                    if (i_memGnt && mem_write) begin
                        complete_c = 1'b1;
                    end else begin
                        state_d = i_memGnt ? WAIT_R : REQ;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (i_valid) begin
                    complete_c = 1'b1;
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (i_memGnt && mem_write) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (i_memGnt) begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (i_memRvalid) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end else if (timeout_c) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_memReq = req_c & ~i_rst;
    assign o_stall  = mem_go & ~(complete_c | abort_c);

    // Writeback bundle next values
    always_comb begin
        valid_d  = complete_c | abort_c;
        mis_d    = (state_q == IDLE) & mem_op & ~aligned;
        err_d    = abort_c;
        result_d = valid_d ? i_resultALU : o_resultALU;
        load_d   = 32'h0;
        if ((state_q == WAIT_R) && i_memRvalid) begin
            load_d = ext_c;
        end
    end

    // State and writeback registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            o_valid      <= 1'b0;
            o_resultALU  <= 32'h0;
            o_loadData   <= 32'h0;
            o_misaligned <= 1'b0;
            o_busErr     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_valid      <= valid_d;
            o_resultALU  <= result_d;
            o_loadData   <= load_d;
            o_misaligned <= mis_d;
            o_busErr     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand-written
// reset/branch sequences and randomized ops against a behavioural model.
module tb_mem_lsu;

    localparam int unsigned TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_zero, i_memGnt, i_memRvalid;
    logic [31:0] i_resultALU, i_storeData, i_outAddr, i_memRdata;
    logic [5:0]  i_ctrlMEM;
    logic        o_stall, o_pcSrc, o_memReq, o_memWe, o_valid, o_misaligned, o_busErr;
    logic [31:0] o_branchAddr, o_memAddr, o_memWdata, o_resultALU, o_loadData;
    logic [3:0]  o_memBe;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mem_lsu #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_resultALU(i_resultALU), .i_storeData(i_storeData),
        .i_outAddr(i_outAddr), .i_zero(i_zero), .i_ctrlMEM(i_ctrlMEM),
        .o_stall(o_stall), .o_pcSrc(o_pcSrc), .o_branchAddr(o_branchAddr),
        .o_memReq(o_memReq), .o_memWe(o_memWe), .o_memAddr(o_memAddr),
        .o_memBe(o_memBe), .o_memWdata(o_memWdata),
        .i_memGnt(i_memGnt), .i_memRvalid(i_memRvalid), .i_memRdata(i_memRdata),
        .o_valid(o_valid), .o_resultALU(o_resultALU), .o_loadData(o_loadData),
        .o_misaligned(o_misaligned), .o_busErr(o_busErr)
    );

    typedef struct {
        logic        v;
        logic [5:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          g;      // cycle (from op start) in which gnt is given
        int          r;      // cycles from grant to rvalid (loads)
        logic        req;    // a memory request is expected
        int          stall;  // expected number of stalled cycles
        logic [31:0] load;
        logic        mis;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic v, input logic [5:0] c, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rd, input int g,
                                 input int r, input logic rq, input int st, input logic [31:0] ld,
                                 input logic mi, input logic er, input logic [3:0] be,
                                 input logic [31:0] wd);
        vec_t t;
        t.v = v; t.ctrl = c; t.addr = a; t.sdata = sd; t.rdata = rd; t.g = g; t.r = r;
        t.req = rq; t.stall = st; t.load = ld; t.mis = mi; t.err = er; t.be = be; t.wdata = wd;
        return t;
    endfunction

    // Behavioural reference: access size, lanes and timing from the rules
    function automatic vec_t model(input logic v, input logic [5:0] c, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [31:0] rd,
                                   input int g, input int r);
        vec_t   t;
        int     size, off, done;
        bit     is_rd, is_wr, memop;
        longint val;
        t = mkv(v, c, a, sd, rd, g, r, 1'b0, 0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        is_rd = c[4];
        is_wr = c[3];
        case (c[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            default: size = 4;
        endcase
        off   = int'(a[1:0]);
        memop = v && (is_rd != is_wr);
        t.req = memop && ((off % size) == 0);
        t.mis = memop && !t.req;
        for (int i = 0; i < 4; i++) begin
            if (size == 4 || (i >= off && i < off + size)) t.be[i] = 1'b1;
            t.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        if (t.req) begin
            done = is_wr ? g : g + r;
            if (done <= int'(TO) - 1) begin
                t.stall = done;
                if (is_rd) begin
                    val = 0;
                    for (int j = 0; j < size; j++)
                        val = val | (longint'(rd[8*(off+j) +: 8]) << (8*j));
                    if (!c[2] && size < 4 && val >= (longint'(1) << (8*size - 1)))
                        val = val - (longint'(1) << (8*size));
                    t.load = val[31:0];
                end
            end else begin
                t.stall = int'(TO) - 1;
                t.err   = 1'b1;
            end
        end
        return t;
    endfunction

    // Run one instruction from an IDLE-slot start until the stall drops,
    // acting as the memory, then check the writeback bundle.
    task automatic do_op(input vec_t t, input string tag);
        logic        z;
        logic [31:0] ta;
        int          k = 0;
        int          stalls = 0;
        bit          go = 1'b1;
        bit          bad_req = 1'b0;
        bit          bad_valid = 1'b0;
        logic        exp_req;
        z  = 1'($urandom);
        ta = $urandom;
        i_valid = t.v; i_ctrlMEM = t.ctrl; i_resultALU = t.addr; i_storeData = t.sdata;
        i_memRdata = t.rdata; i_zero = z; i_outAddr = ta;
        while (go) begin
            i_memGnt    = t.req && (k == t.g);
            i_memRvalid = t.req && t.ctrl[4] && (k == t.g + t.r);
            #1;
            if (k == 0) begin
                chk({tag, ":pcSrc"}, 32'(o_pcSrc), 32'(t.v & t.ctrl[5] & z));
                chk({tag, ":branchAddr"}, o_branchAddr, ta);
            end
            if (k > 0 && o_valid !== 1'b0) bad_valid = 1'b1;
            exp_req = t.req && (k <= t.g);
            if (o_memReq !== exp_req) bad_req = 1'b1;
            if (o_memReq === 1'b1 &&
                (o_memAddr !== {t.addr[31:2], 2'b00} || o_memWe !== t.ctrl[3] ||
                 o_memBe !== t.be || o_memWdata !== t.wdata)) bad_req = 1'b1;
            if (o_stall === 1'b1) stalls++;
            go = (o_stall === 1'b1) && (k < 60);
            @(posedge i_clk);
            #1;
            k++;
        end
        i_memGnt    = 1'b0;
        i_memRvalid = 1'b0;
        chk({tag, ":stall_cycles"}, 32'(stalls), 32'(t.stall));
        chk({tag, ":req_pattern_bad"}, 32'(bad_req), 32'h0);
        chk({tag, ":early_valid"}, 32'(bad_valid), 32'h0);
        chk({tag, ":valid"}, 32'(o_valid), 32'(t.v));
        if (t.v) begin
            chk({tag, ":resultALU"}, o_resultALU, t.addr);
            chk({tag, ":loadData"}, o_loadData, t.load);
            chk({tag, ":misaligned"}, 32'(o_misaligned), 32'(t.mis));
            chk({tag, ":busErr"}, 32'(o_busErr), 32'(t.err));
        end
    endtask

    vec_t vecs[20];

    initial begin
        vec_t t;
        i_rst = 1'b1; i_valid = 1'b0; i_zero = 1'b0; i_memGnt = 1'b0; i_memRvalid = 1'b0;
        i_resultALU = '0; i_storeData = '0; i_outAddr = '0; i_memRdata = '0; i_ctrlMEM = '0;

        vecs[0]  = mkv(1, 6'b000000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0);
        vecs[1]  = mkv(1, 6'b010000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 4, 1, 4, 32'hFFFF_FF80, 0, 0, 4'b1000, 32'h0);
        vecs[2]  = mkv(1, 6'b010100, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 4, 1, 4, 32'h0000_0080, 0, 0, 4'b1000, 32'h0);
        vecs[3]  = mkv(1, 6'b001001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 2, 0, 1, 2, 32'h0, 0, 0, 4'b1100, 32'hBEEF_BEEF);
        vecs[4]  = mkv(1, 6'b010010, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 4'h0, 32'h0);
        vecs[5]  = mkv(1, 6'b010010, 32'h0000_3000, 32'h0, 32'h0, 99, 1, 1, 15, 32'h0, 0, 1, 4'b1111, 32'h0);
        vecs[6]  = mkv(1, 6'b010010, 32'h0000_3000, 32'h0, 32'h1234_5678, 0, 1, 1, 1, 32'h1234_5678, 0, 0, 4'b1111, 32'h0);
        vecs[7]  = mkv(1, 6'b001000, 32'h0000_4001, 32'h0000_00A5, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0, 4'b0010, 32'hA5A5_A5A5);
        vecs[8]  = mkv(1, 6'b010001, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 2, 1, 3, 32'hFFFF_8001, 0, 0, 4'b1100, 32'h0);
        vecs[9]  = mkv(1, 6'b010101, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 2, 1, 3, 32'h0000_8001, 0, 0, 4'b1100, 32'h0);
        vecs[10] = mkv(1, 6'b001001, 32'h0000_6001, 32'h1, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 4'h0, 32'h0);
        vecs[11] = mkv(1, 6'b011010, 32'h0000_7777, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0);
        vecs[12] = mkv(1, 6'b001010, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0, 1, 0, 1, 1, 32'h0, 0, 0, 4'b1111, 32'hDEAD_BEEF);
        vecs[13] = mkv(1, 6'b010010, 32'h0000_8004, 32'h0, 32'hA5A5_0F0F, 5, 10, 1, 15, 32'hA5A5_0F0F, 0, 0, 4'b1111, 32'h0);
        vecs[14] = mkv(1, 6'b010010, 32'h0000_8004, 32'h0, 32'hA5A5_0F0F, 5, 11, 1, 15, 32'h0, 0, 1, 4'b1111, 32'h0);
        vecs[15] = mkv(1, 6'b001010, 32'h0000_8008, 32'h1, 32'h0, 15, 0, 1, 15, 32'h0, 0, 0, 4'b1111, 32'h1);
        vecs[16] = mkv(1, 6'b001010, 32'h0000_8008, 32'h1, 32'h0, 16, 0, 1, 15, 32'h0, 0, 1, 4'b1111, 32'h1);
        vecs[17] = mkv(1, 6'b010011, 32'h0000_9003, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 1, 0, 4'h0, 32'h0);
        vecs[18] = mkv(0, 6'b010010, 32'h0000_9000, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0);
        vecs[19] = mkv(1, 6'b010000, 32'h0000_0100, 32'h0, 32'h0000_007F, 0, 1, 1, 1, 32'h0000_007F, 0, 0, 4'b0001, 32'h0);

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst:valid", 32'(o_valid), 32'h0);
        chk("rst:memReq", 32'(o_memReq), 32'h0);
        chk("rst:resultALU", o_resultALU, 32'h0);
        chk("rst:loadData", o_loadData, 32'h0);
        chk("rst:flags", {30'h0, o_misaligned, o_busErr}, 32'h0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data; a late rvalid must be ignored
        i_valid = 1'b1; i_ctrlMEM = 6'b010010; i_resultALU = 32'h0000_9000; i_memGnt = 1'b1;
        @(posedge i_clk);
        #1;
        i_memGnt = 1'b0;
        @(posedge i_clk);
        #1;
        chk("wr:stall", 32'(o_stall), 32'h1);
        chk("wr:memReq", 32'(o_memReq), 32'h0);
        i_rst = 1'b1; i_valid = 1'b0; i_ctrlMEM = 6'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("wr_rst:valid", 32'(o_valid), 32'h0);
        chk("wr_rst:memReq", 32'(o_memReq), 32'h0);
        chk("wr_rst:stall", 32'(o_stall), 32'h0);
        i_memRvalid = 1'b1; i_memRdata = 32'hFFFF_FFFF;
        @(posedge i_clk);
        #1;
        i_memRvalid = 1'b0;
        chk("stray_rvalid:valid", 32'(o_valid), 32'h0);
        do_op(mkv(1, 6'b010010, 32'h0000_9004, 32'h0, 32'h0BAD_F00D, 0, 1, 1, 1, 32'h0BAD_F00D,
                  0, 0, 4'b1111, 32'h0), "after_rst");

        // Branch redirect
        i_valid = 1'b1; i_ctrlMEM = 6'b100000; i_zero = 1'b1; i_outAddr = 32'hCAFE_0010;
        i_resultALU = 32'h0000_0042;
        #1;
        chk("br:pcSrc_taken", 32'(o_pcSrc), 32'h1);
        chk("br:branchAddr", o_branchAddr, 32'hCAFE_0010);
        i_zero = 1'b0;
        #1;
        chk("br:pcSrc_not_taken", 32'(o_pcSrc), 32'h0);
        @(posedge i_clk);
        #1;
        chk("br:valid", 32'(o_valid), 32'h1);
        i_valid = 1'b0;
        #1;
        chk("br:pcSrc_invalid", 32'(o_pcSrc), 32'h0);

        // Randomized ops against the model
        for (int n = 0; n < 150; n++) begin
            logic        v, rd, wr, br;
            logic [2:0]  f3;
            logic [31:0] a;
            int          kind, g, r;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 3);
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            br   = 1'($urandom_range(0, 1));
            a    = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            g = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
            r = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 3);
            t = model(v, {br, rd, wr, f3}, a, $urandom, $urandom, g, r);
            do_op(t, $sformatf("rnd%0d", n));
        end

        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
